// File: rtl/gtx_rx_sync_if.sv
// GTX RX lane bus: raw K-flag/data words in,
// aligned payload, lock and error status out.
interface gtx_rx_sync_if #(
  parameter int BYTES = 2
);
  logic [BYTES-1:0]   ctrl_i;
  logic [8*BYTES-1:0] data_i;
  logic [8*BYTES-1:0] data_o;
  logic               data_vld_o;
  logic               locked_o;
  logic [15:0]        err_cnt_o;

  modport master (
    output ctrl_i,
    output data_i,
    input  data_o,
    input  data_vld_o,
    input  locked_o,
    input  err_cnt_o
  );

  modport slave (
    input  ctrl_i,
    input  data_i,
    output data_o,
    output data_vld_o,
    output locked_o,
    output err_cnt_o
  );
endinterface

// File: rtl/gtx_rx_sync.sv
// GTX RX comma lock FSM with hysteresis and payload forwarding.
// Optional error counter: define GTX_RX_SYNC_ERR_CNT_EN.
module gtx_rx_sync #(
  parameter int          BYTES    = 2,
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int          LOCK_CNT = 4,
  parameter int          LOSS_CNT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  gtx_rx_sync_if.slave  rx
);

  localparam logic [7:0] LOCK_C = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_C = 8'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t     state_q, state_nx;
  logic [7:0] good_q, good_nx;
  logic [7:0] bad_q, bad_nx;

  logic all_comma;
  logic is_comma;
  logic is_data;
  logic is_inv;

  // every byte of the word equals the comma character
  always_comb begin
    all_comma = 1'b1;
    for (int b = 0; b < BYTES; b++) begin
      if (rx.data_i[8*b +: 8] != COMMA)
        all_comma = 1'b0;
    end
  end

  assign is_comma = (&rx.ctrl_i) & all_comma;
  assign is_data  = ~|rx.ctrl_i;
  assign is_inv   = ~is_comma & ~is_data;

  // state and hysteresis counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HUNT;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_nx;
      good_q  <= good_nx;
      bad_q   <= bad_nx;
    end
  end

  // lock entry/loss decisions
  always_comb begin
    state_nx = state_q;
    good_nx  = good_q;
    bad_nx   = bad_q;
    unique case (state_q)
      HUNT: begin
        if (is_comma) begin
          good_nx  = 8'd1;
          state_nx = (LOCK_C == 8'd1) ? LOCKED : CHECK;
        end
      end
      CHECK: begin
        unique case (1'b1)
          is_comma: begin
            good_nx = good_q + 8'd1;
            if (good_q + 8'd1 == LOCK_C)
              state_nx = LOCKED;
          end
          is_data: begin
            good_nx = good_q;
          end
          default: begin
            good_nx  = '0;
            state_nx = HUNT;
          end
        endcase
      end
      LOCKED: begin
        if (is_inv) begin
          if (bad_q + 8'd1 == LOSS_C) begin
            bad_nx   = '0;
            good_nx  = '0;
            state_nx = HUNT;
          end else begin
            bad_nx = bad_q + 8'd1;
          end
        end else begin
          bad_nx = '0;
        end
      end
      default: begin
        state_nx = HUNT;
        good_nx  = '0;
        bad_nx   = '0;
      end
    endcase
  end

  logic               locked_q;
  logic               vld_q;
  logic [8*BYTES-1:0] data_q;

  // lock flag tracks the state being entered
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      locked_q <= 1'b0;
    else
      locked_q <= (state_nx == LOCKED);
  end

  // forward DATA words seen while already locked
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= (state_q == LOCKED) && is_data;
      if ((state_q == LOCKED) && is_data)
        data_q <= rx.data_i;
    end
  end

  assign rx.locked_o   = locked_q;
  assign rx.data_vld_o = vld_q;
  assign rx.data_o     = data_q;

`ifdef GTX_RX_SYNC_ERR_CNT_EN
  logic [15:0] err_q;

  // saturating count of bad words while locked
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      err_q <= '0;
    else if ((state_q == LOCKED) && is_inv
             && (err_q != 16'hFFFF))
      err_q <= err_q + 16'd1;
  end

  assign rx.err_cnt_o = err_q;
`else
  assign rx.err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_gtx_rx_sync.sv
// Directed bench for gtx_rx_sync: 2-byte lane table
// plus reset and 4-byte width sequences.
module tb_gtx_rx_sync;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  gtx_rx_sync_if #(.BYTES(2)) bus_a ();
  gtx_rx_sync_if #(.BYTES(4)) bus_b ();

  gtx_rx_sync #(
    .BYTES(2), .COMMA(8'hBC),
    .LOCK_CNT(4), .LOSS_CNT(4)
  ) dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx    (bus_a)
  );

  gtx_rx_sync #(
    .BYTES(4), .COMMA(8'hBC),
    .LOCK_CNT(4), .LOSS_CNT(4)
  ) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx    (bus_b)
  );

  int checks = 0;
  int failures = 0;

  function automatic int ee(int n);
`ifdef GTX_RX_SYNC_ERR_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic        vld;
    logic [15:0] dout;
    logic        lk;
    int          err;
  } vec_t;

  vec_t tv[$];

  task automatic add(logic r, logic [1:0] c,
                     logic [15:0] d, logic v,
                     logic [15:0] o, logic l, int e);
    vec_t x;
    x.rst = r; x.ctrl = c; x.data = d;
    x.vld = v; x.dout = o; x.lk = l; x.err = e;
    tv.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    bus_a.ctrl_i = '0; bus_a.data_i = '0;
    bus_b.ctrl_i = '0; bus_b.data_i = '0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic step_a(logic [1:0] c, logic [15:0] d);
    @(negedge clk_i);
    bus_a.ctrl_i = c;
    bus_a.data_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_b(logic [3:0] c, logic [31:0] d);
    @(negedge clk_i);
    bus_b.ctrl_i = c;
    bus_b.data_i = d;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_a(string nm, logic v, logic [15:0] o,
                       logic l, int e);
    chk({nm, ".vld"}, bus_a.data_vld_o, v);
    chk({nm, ".data"}, bus_a.data_o, o);
    chk({nm, ".lock"}, bus_a.locked_o, l);
    chk({nm, ".err"}, bus_a.err_cnt_o, ee(e));
  endtask

  localparam logic [1:0]  K = 2'b11;
  localparam logic [15:0] C = 16'hBCBC;

  initial begin
    bus_a.ctrl_i = '0; bus_a.data_i = '0;
    bus_b.ctrl_i = '0; bus_b.data_i = '0;

    // CHECK abort and HUNT/CHECK data handling
    add(1, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, 2'b10, 16'hBC00, 0, 16'h0, 0, 0);
    add(0, 2'b00, 16'h0000, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, 2'b00, 16'h2222, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 1, 0);
    // lock acquisition from reset
    add(1, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 0, 0);
    add(0, K, C, 0, 16'h0, 1, 0);
    add(0, 2'b00, 16'h1234, 1, 16'h1234, 1, 0);
    add(0, 2'b00, 16'h5678, 1, 16'h5678, 1, 0);
    add(0, K, C, 0, 16'h5678, 1, 0);
    // loss hysteresis
    add(0, 2'b01, 16'h00BC, 0, 16'h5678, 1, 1);
    add(0, K, 16'hBC1C, 0, 16'h5678, 1, 2);
    add(0, 2'b10, 16'hBC00, 0, 16'h5678, 1, 3);
    add(0, 2'b00, 16'h9ABC, 1, 16'h9ABC, 1, 3);
    add(0, 2'b01, 16'h0000, 0, 16'h9ABC, 1, 4);
    add(0, 2'b10, 16'h0000, 0, 16'h9ABC, 1, 5);
    add(0, K, 16'h1CBC, 0, 16'h9ABC, 1, 6);
    add(0, 2'b01, 16'h0000, 0, 16'h9ABC, 0, 7);
    add(0, 2'b00, 16'h1111, 0, 16'h9ABC, 0, 7);
    // relock keeps the error count
    add(0, K, C, 0, 16'h9ABC, 0, 7);
    add(0, K, C, 0, 16'h9ABC, 0, 7);
    add(0, K, C, 0, 16'h9ABC, 0, 7);
    add(0, K, C, 0, 16'h9ABC, 1, 7);
    add(0, 2'b00, 16'hA5A5, 1, 16'hA5A5, 1, 7);

    do_reset();
    #1;
    chk_a("rst_a", 0, 16'h0, 0, 0);
    chk("rst_b.lock", bus_b.locked_o, 0);
    chk("rst_b.err", bus_b.err_cnt_o, 0);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      step_a(tv[i].ctrl, tv[i].data);
      chk_a($sformatf("tv%0d", i), tv[i].vld,
            tv[i].dout, tv[i].lk, tv[i].err);
    end

    // async reset between edges while streaming
    step_a(2'b00, 16'hBEEF);
    chk_a("pre_rst", 1, 16'hBEEF, 1, 7);
    #2;
    rst_i = 1'b1;
    #1;
    chk_a("async_rst", 0, 16'h0, 0, 0);
    @(posedge clk_i);
    #1;
    chk_a("rst_hold", 0, 16'h0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step_a(2'b00, 16'h7777);
    chk_a("post_rst_d", 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step_a(K, C);
      chk_a($sformatf("post_rst_c%0d", i),
            0, 16'h0, 0, 0);
    end
    step_a(2'b00, 16'h3333);
    chk_a("post_rst_chk", 0, 16'h0, 0, 0);
    step_a(K, C);
    chk_a("post_rst_lock", 0, 16'h0, 1, 0);
    step_a(2'b00, 16'h4444);
    chk_a("post_rst_fwd", 1, 16'h4444, 1, 0);

    // 4-byte lane
    do_reset();
    bus_a.ctrl_i = '0;
    for (int i = 0; i < 4; i++) begin
      step_b(4'hF, 32'hBCBCBCBC);
      chk($sformatf("b_c%0d.lock", i),
          bus_b.locked_o, (i == 3) ? 1 : 0);
    end
    step_b(4'hF, 32'hBCBCBC1C);
    chk("b_inv.lock", bus_b.locked_o, 1);
    chk("b_inv.vld", bus_b.data_vld_o, 0);
    chk("b_inv.err", bus_b.err_cnt_o, ee(1));
    step_b(4'h0, 32'hDEADBEEF);
    chk("b_d.vld", bus_b.data_vld_o, 1);
    chk("b_d.data", bus_b.data_o, 32'hDEADBEEF);
    step_b(4'h3, 32'hBCBCBCBC);
    chk("b_mix.err", bus_b.err_cnt_o, ee(2));
    chk("b_mix.data", bus_b.data_o, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
